// File: rtl/imem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_seq_ctrl
// Brief    : PE instruction-memory sequencer; loads the program, then replays
//            it once per accepted data beat with back-to-back queued passes.
// Revision : 1.0
// ============================================================================
module imem_seq_ctrl #(
    parameter int INST_WIDTH    = 64,
    parameter int IM_ADDR_WIDTH = 4,
    parameter int PEND_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_in_valid,
    input  logic [INST_WIDTH-1:0]    inst_in,
    input  logic                     load_done,
    input  logic                     prog_clear,
    input  logic                     data_valid,
    output logic                     im_wr_en,
    output logic [IM_ADDR_WIDTH-1:0] im_wr_addr,
    output logic [INST_WIDTH-1:0]    im_wr_data,
    output logic                     im_rd_en,
    output logic [IM_ADDR_WIDTH-1:0] im_rd_addr,
    output logic                     inst_valid,
    output logic                     inst_last,
    output logic [IM_ADDR_WIDTH:0]   prog_len,
    output logic                     busy,
    output logic                     err_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [IM_ADDR_WIDTH:0]   c_depth    = {1'b1, {IM_ADDR_WIDTH{1'b0}}};
    localparam logic [IM_ADDR_WIDTH:0]   c_ptr_one  = {{IM_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [IM_ADDR_WIDTH-1:0] c_pc_one   = {{(IM_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PEND_WIDTH-1:0]    c_pend_one = {{(PEND_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PEND_WIDTH-1:0]    c_pend_max = {PEND_WIDTH{1'b1}};

    state_t                   state_q,      state_d;
    logic [IM_ADDR_WIDTH:0]   wr_ptr_q,     wr_ptr_d;
    logic [IM_ADDR_WIDTH-1:0] pc_q,         pc_d;
    logic [PEND_WIDTH-1:0]    pending_q,    pending_d;
    logic [IM_ADDR_WIDTH:0]   prog_len_q,   prog_len_d;
    logic                     im_wr_en_q,   im_wr_en_d;
    logic [IM_ADDR_WIDTH-1:0] im_wr_addr_q, im_wr_addr_d;
    logic [INST_WIDTH-1:0]    im_wr_data_q, im_wr_data_d;
    logic                     im_rd_en_q,   im_rd_en_d;
    logic                     inst_valid_q, inst_valid_d;
    logic                     inst_last_q,  inst_last_d;
    logic                     err_ovf_q,    err_ovf_d;

    logic w_loading;
    logic w_wr_req;
    logic w_dv_acc;
    logic w_last;
    logic w_start;

    assign w_loading = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign w_wr_req  = w_loading && inst_in_valid && (inst_in != '0);
    assign w_dv_acc  = data_valid && ((state_q == ST_READY) || (state_q == ST_RUN));
    assign w_last    = (state_q == ST_RUN) && ({1'b0, pc_q} == (prog_len_q - c_ptr_one));
    // A beat arriving in the same cycle as a start counts toward that start,
    // which is what gives the 1-cycle first-read latency and gapless passes.
    assign w_start   = ((state_q == ST_READY) || w_last) && ((pending_q != '0) || w_dv_acc);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        prog_len_d   = prog_len_q;
        im_wr_en_d   = 1'b0;
        im_wr_addr_d = im_wr_addr_q;
        im_wr_data_d = im_wr_data_q;
        im_rd_en_d   = 1'b0;
        err_ovf_d    = err_ovf_q;
        inst_valid_d = im_rd_en_q;
        inst_last_d  = w_last;

        if (w_wr_req) begin
            if (wr_ptr_q == c_depth) begin
                err_ovf_d = 1'b1;
            end else begin
                im_wr_en_d   = 1'b1;
                im_wr_addr_d = wr_ptr_q[IM_ADDR_WIDTH-1:0];
                im_wr_data_d = inst_in;
                wr_ptr_d     = wr_ptr_q + c_ptr_one;
                if (state_q == ST_IDLE) begin
                    state_d = ST_LOAD;
                end
            end
        end

        if ((state_q == ST_LOAD) && load_done) begin
            prog_len_d = wr_ptr_d;
            state_d    = ST_READY;
        end

        if (w_dv_acc && !w_start) begin
            if (pending_q == c_pend_max) begin
                err_ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + c_pend_one;
            end
        end else if (w_start && !w_dv_acc) begin
            pending_d = pending_q - c_pend_one;
        end

        if (w_start) begin
            state_d    = ST_RUN;
            pc_d       = '0;
            im_rd_en_d = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (w_last) begin
                state_d = ST_READY;
                pc_d    = '0;
            end else begin
                pc_d       = pc_q + c_pc_one;
                im_rd_en_d = 1'b1;
            end
        end

        // The read already issued this cycle still completes via inst_valid_d.
        if (prog_clear) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            pc_d       = '0;
            pending_d  = '0;
            prog_len_d = '0;
            im_wr_en_d = 1'b0;
            im_rd_en_d = 1'b0;
            err_ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            pc_q         <= '0;
            pending_q    <= '0;
            prog_len_q   <= '0;
            im_wr_en_q   <= 1'b0;
            im_wr_addr_q <= '0;
            im_wr_data_q <= '0;
            im_rd_en_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_last_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            prog_len_q   <= prog_len_d;
            im_wr_en_q   <= im_wr_en_d;
            im_wr_addr_q <= im_wr_addr_d;
            im_wr_data_q <= im_wr_data_d;
            im_rd_en_q   <= im_rd_en_d;
            inst_valid_q <= inst_valid_d;
            inst_last_q  <= inst_last_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign im_wr_en   = im_wr_en_q;
    assign im_wr_addr = im_wr_addr_q;
    assign im_wr_data = im_wr_data_q;
    assign im_rd_en   = im_rd_en_q;
    assign im_rd_addr = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst_last  = inst_last_q;
    assign prog_len   = prog_len_q;
    assign busy       = (state_q == ST_RUN) || (pending_q != '0);
    assign err_ovf    = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_seq_ctrl
// Brief    : Directed self-checking bench for imem_seq_ctrl.
// Revision : 1.0
// ============================================================================
module tb_imem_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        inst_in_valid;
    logic [63:0] inst_in;
    logic        load_done;
    logic        prog_clear;
    logic        data_valid;
    logic        im_wr_en;
    logic [3:0]  im_wr_addr;
    logic [63:0] im_wr_data;
    logic        im_rd_en;
    logic [3:0]  im_rd_addr;
    logic        inst_valid;
    logic        inst_last;
    logic [4:0]  prog_len;
    logic        busy;
    logic        err_ovf;

    int n_checks;
    int n_fail;

    imem_seq_ctrl #(
        .INST_WIDTH    (64),
        .IM_ADDR_WIDTH (4),
        .PEND_WIDTH    (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .inst_in_valid (inst_in_valid),
        .inst_in       (inst_in),
        .load_done     (load_done),
        .prog_clear    (prog_clear),
        .data_valid    (data_valid),
        .im_wr_en      (im_wr_en),
        .im_wr_addr    (im_wr_addr),
        .im_wr_data    (im_wr_data),
        .im_rd_en      (im_rd_en),
        .im_rd_addr    (im_rd_addr),
        .inst_valid    (inst_valid),
        .inst_last     (inst_last),
        .prog_len      (prog_len),
        .busy          (busy),
        .err_ovf       (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are observed 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        prog_clear = 1'b1;
        step();
        prog_clear = 1'b0;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            inst_in_valid = 1'b1;
            inst_in       = 64'h100 + 64'(i);
            step();
        end
        inst_in_valid = 1'b0;
        inst_in       = '0;
        load_done     = 1'b1;
        step();
        load_done     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cnt;
        int last_cnt;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; inst_in_valid = 1'b0; inst_in = '0;
        load_done = 1'b0; prog_clear = 1'b0; data_valid = 1'b0;

        // Reset state
        step();
        chk("rst_wr_en",  64'(im_wr_en),   64'd0);
        chk("rst_wr_data", im_wr_data,     64'd0);
        chk("rst_rd_en",  64'(im_rd_en),   64'd0);
        chk("rst_busy",   64'(busy),       64'd0);
        chk("rst_plen",   64'(prog_len),   64'd0);
        chk("rst_err",    64'(err_ovf),    64'd0);
        rst = 1'b1;
        step();

        // Load A,B,C with one-cycle registered write
        inst_in_valid = 1'b1; inst_in = 64'hAAAA;
        step();
        chk("ld_a_en",   64'(im_wr_en),   64'd1);
        chk("ld_a_addr", 64'(im_wr_addr), 64'd0);
        chk("ld_a_data", im_wr_data,      64'hAAAA);
        inst_in = 64'hBBBB;
        step();
        chk("ld_b_addr", 64'(im_wr_addr), 64'd1);
        inst_in = 64'hCCCC;
        step();
        chk("ld_c_addr", 64'(im_wr_addr), 64'd2);
        chk("ld_c_data", im_wr_data,      64'hCCCC);
        inst_in_valid = 1'b0; inst_in = '0; load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("ld_plen",   64'(prog_len),   64'd3);
        chk("ld_wr_off", 64'(im_wr_en),   64'd0);

        // Single pass: data_valid at T
        data_valid = 1'b1;
        chk("p1_busy_T", 64'(busy), 64'd0);
        step();
        data_valid = 1'b0;
        chk("p1_en_T1",   64'(im_rd_en),   64'd1);
        chk("p1_addr_T1", 64'(im_rd_addr), 64'd0);
        chk("p1_iv_T1",   64'(inst_valid), 64'd0);
        step();
        chk("p1_addr_T2", 64'(im_rd_addr), 64'd1);
        chk("p1_iv_T2",   64'(inst_valid), 64'd1);
        chk("p1_last_T2", 64'(inst_last),  64'd0);
        step();
        chk("p1_addr_T3", 64'(im_rd_addr), 64'd2);
        chk("p1_last_T3", 64'(inst_last),  64'd0);
        chk("p1_busy_T3", 64'(busy),       64'd1);
        step();
        chk("p1_en_T4",   64'(im_rd_en),   64'd0);
        chk("p1_iv_T4",   64'(inst_valid), 64'd1);
        chk("p1_last_T4", 64'(inst_last),  64'd1);
        chk("p1_busy_T4", 64'(busy),       64'd0);
        step();
        chk("p1_iv_T5",   64'(inst_valid), 64'd0);

        // Zero filter, then three queued gapless passes (beat on last cycle at pending=1)
        do_clear();
        chk("clr_plen", 64'(prog_len), 64'd0);
        wr_cnt = 0;
        inst_in_valid = 1'b1;
        inst_in = 64'hA1; step(); if (im_wr_en) wr_cnt++;
        inst_in = 64'h0;  step(); if (im_wr_en) wr_cnt++;
        inst_in = 64'hB1; step(); if (im_wr_en) wr_cnt++;
        inst_in_valid = 1'b0; inst_in = '0; load_done = 1'b1;
        step(); if (im_wr_en) wr_cnt++;
        load_done = 1'b0;
        chk("zf_writes", 64'(wr_cnt),   64'd2);
        chk("zf_plen",   64'(prog_len), 64'd2);
        chk("zf_b_addr", 64'(im_wr_addr), 64'd1);
        last_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            step();
        end
        data_valid = 1'b0;
        // Observation now at T+3; rewind index so i is cycle offset from T
        for (int i = 3; i <= 8; i++) begin
            if (i <= 6) begin
                chk($sformatf("q_en_%0d", i),   64'(im_rd_en),   64'd1);
                chk($sformatf("q_addr_%0d", i), 64'(im_rd_addr), 64'((i - 1) % 2));
            end else begin
                chk($sformatf("q_en_%0d", i),   64'(im_rd_en),   64'd0);
            end
            chk($sformatf("q_last_%0d", i), 64'(inst_last), 64'((i == 3 || i == 5 || i == 7) ? 1 : 0));
            if (inst_last) last_cnt++;
            step();
        end
        chk("q_last_cnt", 64'(last_cnt), 64'd3);
        chk("q_busy_end", 64'(busy),     64'd0);

        // Load overflow: 17 words, 16 writes
        do_clear();
        wr_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            inst_in_valid = 1'b1;
            inst_in       = 64'h200 + 64'(i);
            step();
            if (im_wr_en) wr_cnt++;
        end
        inst_in_valid = 1'b0; inst_in = '0;
        chk("ovf_writes", 64'(wr_cnt),  64'd16);
        chk("ovf_err",    64'(err_ovf), 64'd1);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("ovf_plen", 64'(prog_len), 64'd16);

        // Pending saturation during 16-long passes
        do_clear();
        chk("clr_err", 64'(err_ovf), 64'd0);
        load_words(16);
        chk("sat_plen", 64'(prog_len), 64'd16);
        last_cnt = 0;
        for (int k = 0; k < 18; k++) begin
            if (k == 17) chk("sat_err_pre", 64'(err_ovf), 64'd0);
            data_valid = 1'b1;
            step();
            if (inst_last) last_cnt++;
        end
        data_valid = 1'b0;
        chk("sat_err", 64'(err_ovf), 64'd1);
        for (int c = 0; c < 300; c++) begin
            step();
            if (inst_last) last_cnt++;
        end
        chk("sat_passes", 64'(last_cnt), 64'd17);
        chk("sat_busy",   64'(busy),     64'd0);

        // prog_clear mid-pass at pc=1 of 4
        do_clear();
        load_words(4);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        chk("pc_addr1", 64'(im_rd_addr), 64'd1);
        prog_clear = 1'b1;
        step();
        prog_clear = 1'b0;
        chk("pc_en",   64'(im_rd_en),   64'd0);
        chk("pc_busy", 64'(busy),       64'd0);
        chk("pc_plen", 64'(prog_len),   64'd0);
        chk("pc_iv",   64'(inst_valid), 64'd1);
        chk("pc_last", 64'(inst_last),  64'd0);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        chk("pc_dv_en",   64'(im_rd_en), 64'd0);
        chk("pc_dv_busy", 64'(busy),     64'd0);

        // Asynchronous reset mid-RUN
        load_words(4);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        chk("ar_pre_en", 64'(im_rd_en), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_en",   64'(im_rd_en),   64'd0);
        chk("ar_addr", 64'(im_rd_addr), 64'd0);
        chk("ar_iv",   64'(inst_valid), 64'd0);
        chk("ar_busy", 64'(busy),       64'd0);
        chk("ar_plen", 64'(prog_len),   64'd0);
        step();
        rst = 1'b1;
        step();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("ar_ld_plen", 64'(prog_len), 64'd0);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        chk("ar_ld_en",   64'(im_rd_en), 64'd0);
        chk("ar_ld_busy", 64'(busy),     64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
